// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types: buffer-register layouts, sequencer state/forwarding
// encodings, per-stage enable bundle and the forwarding priority function.
package pipe_hazard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Which RUN-state rule (below the memory stall) is acting this cycle
  typedef enum logic [1:0] {ACT_NONE, ACT_HALT, ACT_BRANCH, ACT_LOAD_USE} run_act_e;

  typedef struct packed {
    logic [31:0] Curr_Instr;
  } if_id_reg;

  typedef struct packed {
    logic       MemRead;
    logic       Halt;
    logic [4:0] rd;
    logic [4:0] RS_One;
    logic [4:0] RS_Two;
  } id_ex_reg;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [4:0] rd;
  } ex_mem_reg;

  typedef struct packed {
    logic       RegWrite;
    logic [4:0] rd;
  } mem_wb_reg;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } stage_en_t;

  localparam stage_en_t EN_ALL      = 7'b110_1011;
  localparam stage_en_t EN_NONE     = 7'b000_0000;
  localparam stage_en_t EN_BRANCH   = 7'b111_1111;
  localparam stage_en_t EN_DRAIN    = 7'b011_1111;
  localparam stage_en_t EN_LOAD_USE = 7'b000_1111;

  // EX/MEM result is younger than MEM/WB, so it wins when both match
  function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                          input logic       ex_wr,
                                          input logic [4:0] ex_rd,
                                          input logic       wb_wr,
                                          input logic [4:0] wb_rd);
    if (ex_wr && ex_rd != REG_ZERO && ex_rd == rs) return FWD_MEM;
    if (wb_wr && wb_rd != REG_ZERO && wb_rd == rs) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding selects for both source operands.
module pipe_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       ex_wr_i,
  input  logic [4:0] ex_rd_i,
  input  logic       wb_wr_i,
  input  logic [4:0] wb_rd_i,
  output fwd_sel_e   fwd_a_o,
  output fwd_sel_e   fwd_b_o
);

  assign fwd_a_o = fwd_select(rs1_i, ex_wr_i, ex_rd_i, wb_wr_i, wb_rd_i);
  assign fwd_b_o = fwd_select(rs2_i, ex_wr_i, ex_rd_i, wb_wr_i, wb_rd_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/freeze enables, halt drain, memory-wait
// timeout and a saturating stall-cycle counter for the 5-stage RV32 core.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  if_id_reg         if_id_i,
  input  id_ex_reg         id_ex_i,
  input  ex_mem_reg        ex_mem_i,
  input  mem_wb_reg        mem_wb_i,
  input  logic             branch_taken_i,
  input  logic             dmem_ready_i,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W  = $clog2(MEM_WAIT_MAX + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  ctrl_state_e        state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               mem_err_q, mem_err_d;

  stage_en_t   en;
  run_act_e    run_act;
  fwd_sel_e    fwd_a, fwd_b;
  logic [4:0]  rs1, rs2;
  logic        dmem_req, load_use, freeze;
  logic        unused_instr;

  assign rs1          = if_id_i.Curr_Instr[19:15];
  assign rs2          = if_id_i.Curr_Instr[24:20];
  assign unused_instr = ^{if_id_i.Curr_Instr[31:25], if_id_i.Curr_Instr[14:0]};

  pipe_fwd_unit u_fwd (
    .rs1_i   (id_ex_i.RS_One),
    .rs2_i   (id_ex_i.RS_Two),
    .ex_wr_i (ex_mem_i.RegWrite),
    .ex_rd_i (ex_mem_i.rd),
    .wb_wr_i (mem_wb_i.RegWrite),
    .wb_rd_i (mem_wb_i.rd),
    .fwd_a_o (fwd_a),
    .fwd_b_o (fwd_b)
  );

  assign dmem_req = ex_mem_i.MemRead | ex_mem_i.MemWrite;
  assign load_use = id_ex_i.MemRead && (id_ex_i.rd != REG_ZERO) &&
                    ((id_ex_i.rd == rs1) || (id_ex_i.rd == rs2));
  assign run_act  = id_ex_i.Halt    ? ACT_HALT     :
                    branch_taken_i  ? ACT_BRANCH   :
                    load_use        ? ACT_LOAD_USE : ACT_NONE;

  // MEM_WAIT stays frozen until ready even if the request bits drop
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    freeze = 1'b0;
    unique case (state_q)
      RUN, DRAIN: freeze = dmem_req & ~dmem_ready_i;
      MEM_WAIT:   freeze = ~dmem_ready_i;
      default:    freeze = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_err_d   = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (run_act == ACT_HALT) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end
      end
      MEM_WAIT, DRAIN: begin
        if (freeze) begin
          if (wait_cnt_q == WAIT_MAX) begin
            mem_err_d = 1'b1;
            state_d   = HALTED;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end else if (state_q == MEM_WAIT) begin
          // A halt held in EX during the wait must still start the drain
          wait_cnt_d = '0;
          if (run_act == ACT_HALT) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end else begin
            state_d = RUN;
          end
        end else begin
          wait_cnt_d  = '0;
          drain_cnt_d = drain_cnt_q - DRAIN_ONE;
          if (drain_cnt_q == DRAIN_ONE) state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  always_comb begin
    en = EN_ALL;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (freeze) begin
          en = EN_NONE;
        end else begin
          unique case (run_act)
            ACT_HALT:     en = EN_DRAIN;
            ACT_BRANCH:   en = EN_BRANCH;
            ACT_LOAD_USE: en = EN_LOAD_USE;
            default:      en = EN_ALL;
          endcase
        end
      end
      DRAIN:   en = freeze ? EN_NONE : EN_DRAIN;
      default: en = EN_NONE;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q == RUN || state_q == MEM_WAIT) && !en.pc_write && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      stall_q     <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_q     <= stall_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign pc_write     = en.pc_write;
  assign if_id_write  = en.if_id_write;
  assign if_id_flush  = en.if_id_flush;
  assign id_ex_write  = en.id_ex_write;
  assign id_ex_flush  = en.id_ex_flush;
  assign ex_mem_write = en.ex_mem_write;
  assign mem_wb_write = en.mem_wb_write;
  assign forward_a    = fwd_a;
  assign forward_b    = fwd_b;
  assign halted       = (state_q == HALTED);
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; the counter is narrowed to 4 bits so
// saturation is reachable in a few cycles.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CW = 4;

  // Enable vector order: pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem, mem_wb
  localparam logic [6:0] E_ALL  = 7'b1101011;
  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_BR   = 7'b1111111;
  localparam logic [6:0] E_HALT = 7'b0111111;
  localparam logic [6:0] E_LU   = 7'b0001111;

  logic clk = 1'b0;
  logic reset;
  if_id_reg  if_id;
  id_ex_reg  id_ex;
  ex_mem_reg ex_mem;
  mem_wb_reg mem_wb;
  logic branch_taken, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_write, halted, mem_err;
  logic [1:0] forward_a, forward_b;
  logic [CW-1:0] stall_cycles;
  logic [6:0] en_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign en_vec = {pc_write, if_id_write, if_id_flush, id_ex_write,
                   id_ex_flush, ex_mem_write, mem_wb_write};

  pipe_hazard_ctrl #(.MEM_WAIT_MAX(15), .DRAIN_CYCLES(2), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_id_i        (if_id),
    .id_ex_i        (id_ex),
    .ex_mem_i       (ex_mem),
    .mem_wb_i       (mem_wb),
    .branch_taken_i (branch_taken),
    .dmem_ready_i   (dmem_ready),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_write    (id_ex_write),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_write   (ex_mem_write),
    .mem_wb_write   (mem_wb_write),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .halted         (halted),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_id        = '0;
    id_ex        = '0;
    ex_mem       = '0;
    mem_wb       = '0;
    branch_taken = 1'b0;
    dmem_ready   = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #3;
    check("reset_en", 16'(en_vec), 16'(E_ALL));
    check("reset_fwd", 16'({forward_a, forward_b}), 16'h0);
    check("reset_halted", 16'(halted), 16'h0);
    check("reset_mem_err", 16'(mem_err), 16'h0);
    check("reset_stall", 16'(stall_cycles), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Forwarding priority
    ex_mem.RegWrite = 1'b1; ex_mem.rd = 5'd3;
    mem_wb.RegWrite = 1'b1; mem_wb.rd = 5'd3;
    id_ex.RS_One = 5'd3; id_ex.RS_Two = 5'd3;
    #1;
    check("fwd_a_mem", 16'(forward_a), 16'h2);
    check("fwd_b_mem", 16'(forward_b), 16'h2);
    ex_mem.rd = 5'd0;
    #1;
    check("fwd_a_wb", 16'(forward_a), 16'h1);
    ex_mem.RegWrite = 1'b0; mem_wb.RegWrite = 1'b0; ex_mem.rd = 5'd3;
    #1;
    check("fwd_a_none", 16'(forward_a), 16'h0);
    ex_mem.RegWrite = 1'b1; mem_wb.RegWrite = 1'b1; mem_wb.rd = 5'd7;
    id_ex.RS_Two = 5'd7;
    #1;
    check("fwd_split", 16'({forward_a, forward_b}), 16'h9);
    mem_wb.rd = 5'd0; id_ex.RS_Two = 5'd0;
    #1;
    check("fwd_x0", 16'(forward_b), 16'h0);
    idle();

    // Load-use on rs1, then rs2, then rd=x0
    id_ex.MemRead = 1'b1; id_ex.rd = 5'd5;
    if_id.Curr_Instr = 32'h0002_8000;
    #1;
    check("lu_rs1_en", 16'(en_vec), 16'(E_LU));
    tick();
    id_ex = '0;
    #1;
    check("lu_after_en", 16'(en_vec), 16'(E_ALL));
    check("lu_stall", 16'(stall_cycles), 16'h1);
    id_ex.MemRead = 1'b1; id_ex.rd = 5'd5;
    if_id.Curr_Instr = 32'h0050_0000;
    #1;
    check("lu_rs2_en", 16'(en_vec), 16'(E_LU));
    tick();
    check("lu_rs2_stall", 16'(stall_cycles), 16'h2);
    id_ex.rd = 5'd0; if_id.Curr_Instr = 32'h0;
    #1;
    check("lu_x0_en", 16'(en_vec), 16'(E_ALL));
    tick();

    // Branch overrides load-use
    id_ex.MemRead = 1'b1; id_ex.rd = 5'd5;
    if_id.Curr_Instr = 32'h0002_8000;
    branch_taken = 1'b1;
    #1;
    check("br_lu_en", 16'(en_vec), 16'(E_BR));
    tick();
    check("br_stall", 16'(stall_cycles), 16'h2);
    idle();

    // Memory wait: three frozen cycles, released on the fourth
    ex_mem.MemRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_en", 16'(en_vec), 16'(E_NONE));
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    check("wait_release_en", 16'(en_vec), 16'(E_ALL));
    tick();
    check("wait_stall", 16'(stall_cycles), 16'h5);
    ex_mem.MemRead = 1'b0; ex_mem.MemWrite = 1'b1;
    #1;
    check("zero_wait_en", 16'(en_vec), 16'(E_ALL));
    tick();
    check("zero_wait_stall", 16'(stall_cycles), 16'h5);
    idle();

    // Halt: one RUN cycle, two DRAIN cycles, then HALTED
    id_ex.Halt = 1'b1;
    #1;
    check("halt_run_en", 16'(en_vec), 16'(E_HALT));
    tick();
    id_ex = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("drain_en", 16'(en_vec), 16'(E_HALT));
      check("drain_halted", 16'(halted), 16'h0);
      tick();
    end
    check("halted", 16'(halted), 16'h1);
    check("halted_en", 16'(en_vec), 16'(E_NONE));
    check("halt_stall", 16'(stall_cycles), 16'h6);
    tick();
    check("halted_stays", 16'(halted), 16'h1);
    reset = 1'b0;
    #1;
    check("rst_from_halt", 16'(halted), 16'h0);
    check("rst_stall", 16'(stall_cycles), 16'h0);
    reset = 1'b1;
    tick();

    // Asynchronous reset in the middle of DRAIN
    id_ex.Halt = 1'b1;
    tick();
    id_ex = '0;
    #1;
    check("mid_drain_en", 16'(en_vec), 16'(E_HALT));
    reset = 1'b0;
    #1;
    check("mid_drain_rst_en", 16'(en_vec), 16'(E_ALL));
    check("mid_drain_rst_stall", 16'(stall_cycles), 16'h0);
    reset = 1'b1;
    tick();
    check("after_rst_en", 16'(en_vec), 16'(E_ALL));
    check("after_rst_halted", 16'(halted), 16'h0);

    // Counter saturation with a persistent load-use
    id_ex.MemRead = 1'b1; id_ex.rd = 5'd9;
    if_id.Curr_Instr = 32'h0004_8000;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", 16'(stall_cycles), 16'hE);
    for (int i = 0; i < 3; i++) tick();
    check("sat_max", 16'(stall_cycles), 16'hF);
    idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();

    // Memory timeout
    ex_mem.MemRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("timeout_pre_err", 16'(mem_err), 16'h0);
    check("timeout_pre_halt", 16'(halted), 16'h0);
    check("timeout_pre_en", 16'(en_vec), 16'(E_NONE));
    tick();
    check("timeout_err", 16'(mem_err), 16'h1);
    check("timeout_halted", 16'(halted), 16'h1);
    idle();
    tick();
    tick();
    check("timeout_sticky", 16'({mem_err, halted}), 16'h3);
    check("timeout_en", 16'(en_vec), 16'(E_NONE));
    check("timeout_stall", 16'(stall_cycles), 16'hF);
    reset = 1'b0;
    #1;
    check("timeout_rst", 16'({mem_err, halted}), 16'h0);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
